// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Packet-level controller behind a UART receiver. It sets the receiver's
// frame width for each packet phase. It assembles command packets and runs
// them as register-bank writes or reads.
// The packet is a header byte, a 32-bit payload for writes only, and a
// checksum byte when the checksum is enabled.
// Read results leave through a valid/ready handshake.
//
// Optional feature: define UART_CMD_CHECKSUM_EN to enable the checksum phase
// (S_CSUM). When it is undefined, the packet ends after the header (read) or
// after the payload (write).
//
// Ports:
//   clk, rstn       system clock, asynchronous active-low reset
//   ip_rx_data      receiver word (8-bit frame in [7:0], 32-bit frame MSB-first)
//   i_rx_valid      one-cycle pulse marking ip_rx_data valid
//   op_frame_width  bits the receiver collects for its next frame (8 or 32)
//   op_reg_addr     register address
//   op_reg_wdata    register write data
//   o_reg_wr        one-cycle register write strobe
//   o_reg_rd        one-cycle register read strobe
//   ip_reg_rdata    read data, valid the cycle after o_reg_rd
//   op_tx_data      read result toward the transmitter
//   o_tx_valid      op_tx_data valid
//   i_tx_ready      transmitter accepts op_tx_data
//   o_busy          high outside S_HDR
//   op_err_count    saturating error event counter
module uart_cmd_sequencer #(
  parameter int p_timeout_cycles = 1000000,
  parameter int pw_timeout       = 20,
  parameter int pw_index_width   = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [31:0]               ip_rx_data,
  input  logic                      i_rx_valid,
  output logic [pw_index_width-1:0] op_frame_width,
  output logic [3:0]                op_reg_addr,
  output logic [31:0]               op_reg_wdata,
  output logic                      o_reg_wr,
  output logic                      o_reg_rd,
  input  logic [31:0]               ip_reg_rdata,
  output logic [31:0]               op_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_busy,
  output logic [7:0]                op_err_count
);

  localparam logic [2:0] S_HDR     = 3'd0;
  localparam logic [2:0] S_PAYLOAD = 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd2;
`endif
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_RDCAP   = 3'd4;
  localparam logic [2:0] S_TX      = 3'd5;

  localparam logic [pw_index_width-1:0] c_width_8  = pw_index_width'(8);
  localparam logic [pw_index_width-1:0] c_width_32 = pw_index_width'(32);
  localparam logic [pw_timeout-1:0]     c_tmo_last = pw_timeout'(p_timeout_cycles - 1);

  logic [2:0]            state;
  logic                  rw;
  logic [pw_timeout-1:0] tcnt;
  logic                  in_window;
  logic                  timeout_hit;
  logic                  err_evt;
  logic [7:0]            rx_byte;

  assign rx_byte = ip_rx_data[7:0];
  assign o_busy  = (state != S_HDR);

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] csum;
  assign in_window = (state == S_PAYLOAD) || (state == S_CSUM);
`else
  assign in_window = (state == S_PAYLOAD);
`endif

  // An arriving byte takes priority over a timeout in the same cycle.
  assign timeout_hit = in_window && !i_rx_valid && (tcnt == c_tmo_last);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    err_evt = 1'b0;
    case (state)
      S_HDR:                 err_evt = i_rx_valid && (ip_rx_data[6:4] != 3'b000);
      S_PAYLOAD:             err_evt = timeout_hit;
`ifdef UART_CMD_CHECKSUM_EN
      S_CSUM:                err_evt = i_rx_valid ? (rx_byte != csum) : timeout_hit;
`endif
      S_EXEC, S_RDCAP, S_TX: err_evt = i_rx_valid;
      default:               err_evt = 1'b0;
    endcase
  end

  // NOTE: this bank holds only control and data flops, no memory array, so every register is reset to a defined value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_HDR;
      rw             <= 1'b0;
      tcnt           <= '0;
      op_frame_width <= c_width_8;
      op_reg_addr    <= '0;
      op_reg_wdata   <= '0;
      o_reg_wr       <= 1'b0;
      o_reg_rd       <= 1'b0;
      op_tx_data     <= '0;
      o_tx_valid     <= 1'b0;
      op_err_count   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the clock edge.
      o_reg_wr <= 1'b0;
      o_reg_rd <= 1'b0;

      if (i_rx_valid || !in_window || timeout_hit) tcnt <= '0;
      else                                         tcnt <= tcnt + 1'b1;

      if (err_evt && (op_err_count != 8'hFF)) op_err_count <= op_err_count + 1'b1;

      case (state)
        S_HDR: begin
          if (i_rx_valid && (ip_rx_data[6:4] == 3'b000)) begin
            op_reg_addr <= rx_byte[3:0];
            rw          <= rx_byte[7];
`ifdef UART_CMD_CHECKSUM_EN
            csum        <= rx_byte;
`endif
            if (rx_byte[7]) begin
              state          <= S_PAYLOAD;
              op_frame_width <= c_width_32;
            end else begin
`ifdef UART_CMD_CHECKSUM_EN
              state          <= S_CSUM;
`else
              state          <= S_EXEC;
`endif
              op_frame_width <= c_width_8;
            end
          end
        end
        S_PAYLOAD: begin
          if (i_rx_valid) begin
            op_reg_wdata   <= ip_rx_data;
            op_frame_width <= c_width_8;
`ifdef UART_CMD_CHECKSUM_EN
            csum  <= csum ^ ip_rx_data[31:24] ^ ip_rx_data[23:16]
                          ^ ip_rx_data[15:8]  ^ ip_rx_data[7:0];
            state <= S_CSUM;
`else
            state <= S_EXEC;
`endif
          end else if (timeout_hit) begin
            state          <= S_HDR;
            op_frame_width <= c_width_8;
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        S_CSUM: begin
          if (i_rx_valid) begin
            state <= (rx_byte == csum) ? S_EXEC : S_HDR;
          end else if (timeout_hit) begin
            state <= S_HDR;
          end
        end
`endif
        S_EXEC: begin
          if (rw) begin
            o_reg_wr <= 1'b1;
            state    <= S_HDR;
          end else begin
            o_reg_rd <= 1'b1;
            state    <= S_RDCAP;
          end
        end
        S_RDCAP: begin
          // The read strobe is registered, so read data arrives the cycle
          // after it is visible; capture only once the strobe has dropped.
          if (!o_reg_rd) begin
            op_tx_data <= ip_reg_rdata;
            o_tx_valid <= 1'b1;
            state      <= S_TX;
          end
        end
        S_TX: begin
          if (o_tx_valid && i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
// Self-checking bench for uart_cmd_sequencer. Each scenario is a task.
// Expected register writes, reads and transmit words go into scoreboard
// queues when stimulus is driven. A negedge monitor pops them and compares
// when the DUT produces the strobe or handshake.
// The same stimulus also runs in a build with UART_CMD_CHECKSUM_EN defined.
module tb_uart_cmd_sequencer;

  localparam int P = 100;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ip_rx_data;
  logic        i_rx_valid;
  logic [9:0]  op_frame_width;
  logic [3:0]  op_reg_addr;
  logic [31:0] op_reg_wdata;
  logic        o_reg_wr;
  logic        o_reg_rd;
  logic [31:0] ip_reg_rdata;
  logic [31:0] op_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic [7:0]  op_err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [3:0]  rd_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] regs[16];

  always #5 clk = ~clk;

  uart_cmd_sequencer #(
    .p_timeout_cycles(P),
    .pw_timeout(20),
    .pw_index_width(10)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ip_rx_data(ip_rx_data),
    .i_rx_valid(i_rx_valid),
    .op_frame_width(op_frame_width),
    .op_reg_addr(op_reg_addr),
    .op_reg_wdata(op_reg_wdata),
    .o_reg_wr(o_reg_wr),
    .o_reg_rd(o_reg_rd),
    .ip_reg_rdata(ip_reg_rdata),
    .op_tx_data(op_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_busy(o_busy),
    .op_err_count(op_err_count)
  );

  // Register bank model: read data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (o_reg_rd) ip_reg_rdata <= regs[op_reg_addr];
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_reg_wr) begin
        n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr=%0h data=%08h, expected none", op_reg_addr, op_reg_wdata);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          if ({op_reg_addr, op_reg_wdata} !== {e.addr, e.data}) begin
            n_fail++;
            $display("FAIL write_data: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                     op_reg_addr, op_reg_wdata, e.addr, e.data);
          end
        end
      end
      if (o_reg_rd) begin
        n_checks++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: got addr=%0h, expected none", op_reg_addr);
        end else begin
          logic [3:0] a;
          a = rd_q.pop_front();
          if (op_reg_addr !== a) begin
            n_fail++;
            $display("FAIL read_addr: got %0h, expected %0h", op_reg_addr, a);
          end
        end
      end
      if (o_tx_valid && i_tx_ready) begin
        n_checks++;
        if (tx_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tx: got %08h, expected none", op_tx_data);
        end else begin
          logic [31:0] t;
          t = tx_q.pop_front();
          if (op_tx_data !== t) begin
            n_fail++;
            $display("FAIL tx_data: got %08h, expected %08h", op_tx_data, t);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d);
    @(negedge clk);
    ip_rx_data = d;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
    ip_rx_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] h, input logic [31:0] d);
    return h ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  task automatic send_write(input logic [3:0] a, input logic [31:0] d);
    logic [7:0] h;
    h = {4'h8, a};
    wr_q.push_back('{addr: a, data: d});
    send({24'h0, h});
    send(d);
`ifdef UART_CMD_CHECKSUM_EN
    send({24'h0, csum_of(h, d)});
`endif
  endtask

  task automatic check_err(input string name);
    n_checks++;
    if (op_err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d, expected %0d", name, op_err_count, exp_err);
    end
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if ({o_busy, op_frame_width} !== {1'b0, 10'd8}) begin
      n_fail++;
      $display("FAIL %s idle: got busy=%0b width=%0d, expected busy=0 width=8", name, o_busy, op_frame_width);
    end
  endtask

  task automatic check_width(input string name, input int w);
    n_checks++;
    if (op_frame_width !== 10'(w)) begin
      n_fail++;
      $display("FAIL %s frame_width: got %0d, expected %0d", name, op_frame_width, w);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({op_frame_width, op_reg_addr, op_reg_wdata, o_reg_wr, o_reg_rd, op_tx_data, o_tx_valid, o_busy, op_err_count}
        !== {10'd8, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL %s reset_values: got width=%0d addr=%0h wdata=%08h wr=%0b rd=%0b tx=%08h txv=%0b busy=%0b err=%0d, expected width=8 and all others 0",
               name, op_frame_width, op_reg_addr, op_reg_wdata, o_reg_wr, o_reg_rd, op_tx_data, o_tx_valid, o_busy, op_err_count);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (wr_q.size() + rd_q.size() + tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got %0d/%0d/%0d pending wr/rd/tx, expected 0/0/0",
               name, wr_q.size(), rd_q.size(), tx_q.size());
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle(3);
    check_reset_values("reset");
    rstn = 1'b1;
    idle(2);
    check_reset_values("after_release");
  endtask

  task automatic test_write;
    check_width("wr_before_hdr", 8);
    wr_q.push_back('{addr: 4'h3, data: 32'hDEADBEEF});
    send(32'h83);
    check_width("wr_after_hdr", 32);
    send(32'hDEADBEEF);
    check_width("wr_after_payload", 8);
`ifdef UART_CMD_CHECKSUM_EN
    send(32'hA1);
    check_width("wr_after_csum", 8);
`endif
    // The last byte's valid was sampled one edge ago. The strobe must stay
    // low now and be high at the next sample.
    n_checks++;
    if (o_reg_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_latency_early: got o_reg_wr=%0b, expected 0", o_reg_wr);
    end
    @(negedge clk);
    n_checks++;
    if (o_reg_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_latency: got o_reg_wr=%0b, expected 1", o_reg_wr);
    end
    idle(3);
    check_idle("write");
    check_err("write");
    check_drained("write");
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  task automatic test_bad_csum;
    send(32'h83);
    send(32'hDEADBEEF);
    send(32'h00);
    exp_err++;
    idle(4);
    check_idle("bad_csum");
    check_err("bad_csum");
    check_drained("bad_csum");
  endtask
`endif

  task automatic test_read_backpressure;
    int cyc;
    regs[5] = 32'h12345678;
    i_tx_ready = 1'b0;
    rd_q.push_back(4'h5);
    tx_q.push_back(32'h12345678);
    send(32'h05);
`ifdef UART_CMD_CHECKSUM_EN
    send(32'h05);
`endif
    cyc = 0;
    while (!o_tx_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!o_tx_valid || op_tx_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL read_result: got valid=%0b data=%08h after %0d cycles, expected valid=1 data=12345678",
               o_tx_valid, op_tx_data, cyc);
    end
    // A byte arriving while the result waits is dropped and counted.
    send(32'h81);
    exp_err++;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({o_tx_valid, op_tx_data} !== {1'b1, 32'h12345678}) begin
        n_fail++;
        $display("FAIL read_hold: got valid=%0b data=%08h, expected valid=1 data=12345678", o_tx_valid, op_tx_data);
      end
    end
    @(posedge clk);
    #1 i_tx_ready = 1'b1;
    @(posedge clk);
    #1 i_tx_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_release: got o_tx_valid=%0b, expected 0", o_tx_valid);
    end
    idle(2);
    check_idle("read");
    check_err("read");
    check_drained("read");
  endtask

  task automatic test_timeout;
    int cyc;
    send(32'h81);
    cyc = 0;
    while (o_busy && cyc < 3 * P) begin
      @(negedge clk);
      cyc++;
    end
    exp_err++;
    n_checks++;
    if (cyc != P) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d, expected %0d", cyc, P);
    end
    check_idle("timeout");
    check_err("timeout");
    send_write(4'hA, 32'hCAFEF00D);
    idle(4);
    check_drained("after_timeout");
    check_err("after_timeout");
  endtask

  task automatic test_reserved_saturation;
    send(32'h90);
    exp_err++;
    idle(1);
    check_idle("reserved");
    check_err("reserved");
    for (int i = 0; i < 300; i++) begin
      send(32'hF0);
      if (exp_err < 255) exp_err++;
    end
    idle(2);
    check_err("saturation");
  endtask

  task automatic test_reset_mid_payload;
    send(32'h83);
    check_width("mid_payload", 32);
    @(negedge clk);
    rstn = 1'b0;
    exp_err = 0;
    idle(2);
    check_reset_values("mid_reset");
    rstn = 1'b1;
    idle(2);
    send_write(4'h2, 32'h0BADF00D);
    idle(4);
    check_drained("after_mid_reset");
    check_err("after_mid_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    ip_rx_data   = '0;
    i_rx_valid   = 1'b0;
    i_tx_ready   = 1'b0;
    ip_reg_rdata = '0;
    test_reset();
    test_write();
`ifdef UART_CMD_CHECKSUM_EN
    test_bad_csum();
`endif
    test_read_backpressure();
    test_timeout();
    test_reserved_saturation();
    test_reset_mid_payload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
